// File: rtl/simd_result_unpacker.sv
// Unpacks the fracturable multiplier's SIMD result bus into per-lane values,
// accumulates each lane over acc_len beats and drains the lane sums serially.
module simd_result_unpacker #(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic             sign,
  input  logic [44:0]      result_0,
  input  logic [44:0]      result_1,
  input  logic [15:0]      result_SIMD_carry,
  input  logic [LEN_W-1:0] acc_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [2:0]       out_lane,
  output logic             out_last
);

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned R_W       = 90;

  typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc    [NUM_LANES];
  logic [ACC_W-1:0] acc_nx [NUM_LANES];
  logic [ACC_W-1:0] lane   [NUM_LANES];
  logic [LEN_W-1:0] cnt, cnt_nx, len_q, len_nx, len_eff;
  logic [1:0]       mode_q, mode_nx, mode_eff;
  logic [2:0]       idx, idx_nx;
  logic [R_W-1:0]   r_word;
  logic             first_beat, accept;
  logic             in_ready_nx, out_valid_nx, out_last_nx;
  logic [ACC_W-1:0] out_data_nx;
  logic [2:0]       out_lane_nx;

  // Sign- or zero-extend the low w bits of f to ACC_W.
  function automatic logic [ACC_W-1:0] ext(input logic [44:0] f, input int unsigned w,
                                           input logic s);
    logic [ACC_W-1:0] mask;
    logic [ACC_W-1:0] v;
    mask = {ACC_W{1'b1}} << w;
    v    = ACC_W'(f) & ~mask;
    if (s && f[6'(w - 1)]) v = v | mask;
    return v;
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] m);
    case (m)
      2'b00:   return 3'd0;
      2'b01:   return 3'd1;
      2'b10:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  assign r_word     = {result_1, result_0};
  assign first_beat = (cnt == '0);
  assign mode_eff   = first_beat ? mode : mode_q;
  assign len_eff    = first_beat ? ((acc_len == '0) ? LEN_W'(1) : acc_len) : len_q;
  assign accept     = in_valid && in_ready;

  // Lane extraction; lanes beyond the active lane count read as zero.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      lane[k] = '0;
      case (mode_eff)
        2'b00: if (k == 0) lane[k] = ext(45'(r_word), 45, sign);
        2'b01: if (k < 2)  lane[k] = ext(45'(r_word >> (45 * k)), 45, sign);
        2'b10: if (k < 4)  lane[k] = ext(45'({2'(result_SIMD_carry >> (2 * k)),
                                               22'(r_word >> (22 * k))}), 24, sign);
        default:           lane[k] = ext(45'({2'(result_SIMD_carry >> (2 * k)),
                                               11'(r_word >> (11 * k))}), 13, sign);
      endcase
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    len_nx   = len_q;
    mode_nx  = mode_q;
    idx_nx   = idx;

    case (state)
      ST_ACCUM: begin
        if (accept) begin
          if (first_beat) begin
            mode_nx = mode;
            len_nx  = len_eff;
            cnt_nx  = LEN_W'(1);
            for (int k = 0; k < NUM_LANES; k++) acc_nx[k] = lane[k];
          end else begin
            cnt_nx = cnt + LEN_W'(1);
            for (int k = 0; k < NUM_LANES; k++) acc_nx[k] = acc[k] + lane[k];
          end
          if (cnt_nx == len_eff) begin
            state_nx = ST_DRAIN;
            idx_nx   = '0;
          end
        end
      end
      default: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_nx = ST_ACCUM;
            idx_nx   = '0;
            cnt_nx   = '0;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
    endcase

    in_ready_nx  = (state_nx == ST_ACCUM);
    out_valid_nx = (state_nx == ST_DRAIN);
    out_data_nx  = out_valid_nx ? acc_nx[idx_nx] : '0;
    out_lane_nx  = out_valid_nx ? idx_nx : 3'd0;
    out_last_nx  = out_valid_nx && (idx_nx == last_idx(mode_nx));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ACCUM;
      cnt       <= '0;
      len_q     <= '0;
      mode_q    <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_last  <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) acc[k] <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      len_q     <= len_nx;
      mode_q    <= mode_nx;
      idx       <= idx_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_lane  <= out_lane_nx;
      out_last  <= out_last_nx;
      for (int k = 0; k < NUM_LANES; k++) acc[k] <= acc_nx[k];
    end
  end

endmodule

// File: tb/tb_simd_result_unpacker.sv
// Randomised and directed bench for simd_result_unpacker with an arithmetic lane model.
module tb_simd_result_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic        sign;
  logic [44:0] result_0;
  logic [44:0] result_1;
  logic [15:0] result_SIMD_carry;
  logic [7:0]  acc_len;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [2:0]  out_lane;
  logic        out_last;

  int vectors = 0;
  int miscompares = 0;

  logic [47:0] col_d   [8];
  logic [2:0]  col_ln  [8];
  logic        col_lst [8];
  int          col_n;
  bit          col_lat, col_stable, col_inr, col_timeout, col_post_valid, col_post_ready;

  simd_result_unpacker #(.ACC_W(48), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sign(sign), .result_0(result_0), .result_1(result_1),
    .result_SIMD_carry(result_SIMD_carry), .acc_len(acc_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Reference: lane values as signed/unsigned integers from field arithmetic.
  function automatic void lanes_of(input logic [1:0] md, input logic sg, input logic [44:0] r0,
                                   input logic [44:0] r1, input logic [15:0] c,
                                   output longint v [8]);
    logic [89:0] r;
    int n, nl, w;
    bit guard;
    longint f;
    r = {r1, r0};
    case (md)
      2'b00:   begin n = 45; nl = 1; guard = 0; end
      2'b01:   begin n = 45; nl = 2; guard = 0; end
      2'b10:   begin n = 22; nl = 4; guard = 1; end
      default: begin n = 11; nl = 8; guard = 1; end
    endcase
    for (int k = 0; k < 8; k++) begin
      if (k >= nl) begin
        v[k] = 0;
      end else begin
        f = longint'(64'((r >> (k * n)) & ((90'(1) << n) - 90'(1))));
        w = n;
        if (guard) begin
          f = f + (longint'((c >> (2 * k)) & 16'h3) << n);
          w = n + 2;
        end
        if (sg && f >= (64'sd1 <<< (w - 1))) f = f - (64'sd1 <<< w);
        v[k] = f;
      end
    end
  endfunction

  function automatic int nl_of(input logic [1:0] md);
    return (md == 2'b00) ? 1 : (md == 2'b01) ? 2 : (md == 2'b10) ? 4 : 8;
  endfunction

  task automatic send_beat(input logic [1:0] md, input logic sg, input logic [44:0] r0,
                           input logic [44:0] r1, input logic [15:0] c, input logic [7:0] len);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_beat: in_ready=%0b after %0d cycles, required 1", in_ready, w);
    end
    mode = md; sign = sg; result_0 = r0; result_1 = r1; result_SIMD_carry = c; acc_len = len;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  // Drains one block, recording accepted beats; upstream keeps poking in_valid meanwhile.
  task automatic collect(input int stall_lane);
    int cyc = 0, stall = 0;
    bit done = 0, first = 1, prev_stalled = 0, rdy;
    logic [47:0] hd; logic [2:0] hl; logic hlast;
    col_n = 0; col_lat = 0; col_stable = 1; col_inr = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'($urandom_range(0, 1));
      mode = 2'($urandom); result_0 = 45'({$urandom, $urandom}); acc_len = 8'($urandom);
      if (first) col_lat = out_valid;
      first = 0;
      if (out_valid) begin
        if (in_ready) col_inr = 0;
        if (prev_stalled && (out_data !== hd || out_lane !== hl || out_last !== hlast))
          col_stable = 0;
        if (stall_lane >= 0) begin
          rdy = !(int'(out_lane) == stall_lane && stall < 4);
          if (!rdy) stall++;
        end else begin
          rdy = ($urandom_range(0, 2) != 0);
        end
        out_ready = rdy;
        hd = out_data; hl = out_lane; hlast = out_last;
        prev_stalled = !rdy;
        if (rdy) begin
          col_d[col_n] = out_data; col_ln[col_n] = out_lane; col_lst[col_n] = out_last;
          col_n++;
          if (out_last || col_n == 8) done = 1;
        end
      end else begin
        out_ready = 1'b0;
        prev_stalled = 0;
      end
    end
    col_timeout = !done;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    col_post_valid = out_valid;
    col_post_ready = in_ready;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 48'd0 ||
        out_lane !== 3'd0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%0b vld=%0b data=%h lane=%0d last=%0b, required 1 0 0 0 0",
               in_ready, out_valid, out_data, out_lane, out_last);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: rdy=%0b vld=%0b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single;
    send_beat(2'b00, 1'b0, 45'h0_0000_1234, 45'd0, 16'h0, 8'd1);
    collect(-1);
    vectors++;
    if (!col_lat || col_timeout || col_n != 1 || col_d[0] !== 48'h1234 || col_ln[0] !== 3'd0 ||
        col_lst[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL single: lat=%0b n=%0d data=%h lane=%0d last=%0b, required 1 1 1234 0 1",
               col_lat, col_n, col_d[0], col_ln[0], col_lst[0]);
    end
    vectors++;
    if (col_post_valid !== 1'b0 || col_post_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_return: vld=%0b rdy=%0b, required 0 1", col_post_valid, col_post_ready);
    end
  endtask

  task automatic test_lanes_8x;
    logic [89:0] r = '0;
    for (int k = 0; k < 8; k++) r[11 * k +: 11] = 11'(k + 1);
    send_beat(2'b11, 1'b0, r[44:0], r[89:45], 16'h0, 8'd1);
    collect(-1);
    vectors++;
    if (col_n != 8 || col_timeout) begin
      miscompares++;
      $display("FAIL lanes8_count: got %0d beats, required 8", col_n);
    end
    for (int k = 0; k < col_n; k++) begin
      vectors++;
      if (col_d[k] !== 48'(k + 1) || col_ln[k] !== 3'(k) || col_lst[k] !== (k == 7)) begin
        miscompares++;
        $display("FAIL lanes8[%0d]: data=%0d lane=%0d last=%0b, required %0d %0d %0b",
                 k, col_d[k], col_ln[k], col_lst[k], k + 1, k, k == 7);
      end
    end
  endtask

  task automatic test_sign_ext;
    send_beat(2'b11, 1'b1, 45'h7FF, 45'd0, 16'h3, 8'd1);
    collect(-1);
    vectors++;
    if (col_n != 8 || col_d[0] !== 48'hFFFF_FFFF_FFFF || col_d[1] !== 48'd0) begin
      miscompares++;
      $display("FAIL sign_ext_signed: n=%0d lane0=%h lane1=%h, required 8 ffffffffffff 0",
               col_n, col_d[0], col_d[1]);
    end
    send_beat(2'b11, 1'b0, 45'h7FF, 45'd0, 16'h3, 8'd1);
    collect(-1);
    vectors++;
    if (col_n != 8 || col_d[0] !== 48'h1FFF) begin
      miscompares++;
      $display("FAIL sign_ext_unsigned: n=%0d lane0=%h, required 8 1fff", col_n, col_d[0]);
    end
  endtask

  task automatic test_mode_latch;
    for (int b = 0; b < 3; b++)
      send_beat((b == 0) ? 2'b01 : 2'b11, 1'b0, 45'd5, 45'd7, 16'hFFFF, (b == 0) ? 8'd3 : 8'd1);
    collect(-1);
    vectors++;
    if (col_n != 2 || col_d[0] !== 48'd15 || col_d[1] !== 48'd21 || col_lst[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL mode_latch: n=%0d lane0=%0d lane1=%0d, required 2 15 21", col_n,
               col_d[0], col_d[1]);
    end
  endtask

  task automatic test_backpressure;
    longint v [8];
    logic [44:0] r0 = 45'({$urandom, $urandom});
    logic [44:0] r1 = 45'({$urandom, $urandom});
    logic [15:0] c = 16'($urandom);
    lanes_of(2'b10, 1'b1, r0, r1, c, v);
    send_beat(2'b10, 1'b1, r0, r1, c, 8'd1);
    collect(2);
    vectors++;
    if (!col_stable || !col_inr || col_n != 4) begin
      miscompares++;
      $display("FAIL backpressure: stable=%0b in_ready_low=%0b n=%0d, required 1 1 4",
               col_stable, col_inr, col_n);
    end
    for (int k = 0; k < col_n; k++) begin
      vectors++;
      if (col_d[k] !== 48'(v[k]) || col_ln[k] !== 3'(k)) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: data=%h lane=%0d, required %h %0d", k, col_d[k],
                 col_ln[k], 48'(v[k]), k);
      end
    end
  endtask

  task automatic test_random_blocks;
    longint v [8];
    longint acc [8];
    logic [1:0] md;
    logic [7:0] len;
    int eff, nl;
    for (int blk = 0; blk < 24; blk++) begin
      md  = 2'($urandom);
      len = 8'($urandom_range(0, 4));
      eff = (len == 0) ? 1 : int'(len);
      nl  = nl_of(md);
      for (int k = 0; k < 8; k++) acc[k] = 0;
      for (int b = 0; b < eff; b++) begin
        logic sg = 1'($urandom);
        logic [44:0] r0 = 45'({$urandom, $urandom});
        logic [44:0] r1 = 45'({$urandom, $urandom});
        logic [15:0] c = 16'($urandom);
        lanes_of(md, sg, r0, r1, c, v);
        for (int k = 0; k < 8; k++) acc[k] = acc[k] + v[k];
        send_beat((b == 0) ? md : 2'($urandom), sg, r0, r1, c,
                  (b == 0) ? len : 8'($urandom));
      end
      collect(-1);
      vectors++;
      if (!col_lat || col_timeout || col_n != nl || !col_inr) begin
        miscompares++;
        $display("FAIL random%0d_shape: lat=%0b n=%0d in_ready_low=%0b, required 1 %0d 1",
                 blk, col_lat, col_n, col_inr, nl);
      end
      for (int k = 0; k < col_n; k++) begin
        vectors++;
        if (col_d[k] !== 48'(acc[k]) || col_ln[k] !== 3'(k) || col_lst[k] !== (k == nl - 1)) begin
          miscompares++;
          $display("FAIL random%0d[%0d]: data=%h lane=%0d last=%0b, required %h %0d %0b", blk, k,
                   col_d[k], col_ln[k], col_lst[k], 48'(acc[k]), k, k == nl - 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    send_beat(2'b11, 1'b0, 45'({$urandom, $urandom}), 45'({$urandom, $urandom}), 16'hFFFF, 8'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_lane !== 3'd1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_drain_setup: lane=%0d vld=%0b, required 1 1", out_lane, out_valid);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 48'd0 || out_lane !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_drain_reset: vld=%0b rdy=%0b data=%h lane=%0d, required 0 1 0 0",
               out_valid, in_ready, out_data, out_lane);
    end
    @(negedge clk);
    reset = 1'b0;
    send_beat(2'b00, 1'b0, 45'd9, 45'd0, 16'h0, 8'd1);
    collect(-1);
    vectors++;
    if (col_n != 1 || col_d[0] !== 48'd9 || col_lst[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL after_reset_block: n=%0d data=%0d last=%0b, required 1 9 1", col_n,
               col_d[0], col_lst[0]);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mode = 2'b00; sign = 1'b0; result_0 = '0; result_1 = '0;
    result_SIMD_carry = '0; acc_len = 8'd1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_lanes_8x();
    test_sign_ext();
    test_mode_latch();
    test_backpressure();
    test_random_blocks();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simd_result_unpacker.md
Name: simd_result_unpacker

Overview:
- Downstream consumer of the fracturable multiplier's packed SIMD output bus ({result_1, result_0, result_SIMD_carry}).
- Extracts each lane's value from the packed word and applies per-lane sign or zero extension.
- Accumulates each lane over a block of acc_len input beats, then drains the lane sums serially over a valid/ready stream.
- Sits between the multiplier array and the accumulation/writeback fabric.

Parameters:
- ACC_W, 48, accumulator and output width; all arithmetic wraps modulo 2^ACC_W.
- LEN_W, 8, width of acc_len.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  packed input word present.
- in_ready  out  1  block can accept an input beat.
- mode  in  2  00=27x18, 01=sum_9x9, 10=sum_4x4, 11=sum_2x2.
- sign  in  1  1 = lanes are signed.
- result_0  in  45  packed low half.
- result_1  in  45  packed high half.
- result_SIMD_carry  in  16  per-lane guard bits.
- acc_len  in  LEN_W  beats per block; 0 is treated as 1.
- out_valid  out  1  lane sum present.
- out_ready  in  1  consumer accepts the lane sum.
- out_data  out  ACC_W  lane sum.
- out_lane  out  3  lane index.
- out_last  out  1  marks the final lane of the block.

Behaviour:
- Input handshake: a beat is accepted when in_valid && in_ready.
- Packed word R = {result_1, result_0}, 90 bits.
- Lane map (NL = lanes in mode):
  - mode 00: NL=1. L0 = R[44:0]. No guard bits.
  - mode 01: NL=2. Lk = R[45k +: 45]. No guard bits.
  - mode 10: NL=4. Lk = {carry[2k+1:2k], R[22k +: 22]}, 24 bits.
  - mode 11: NL=8. Lk = {carry[2k+1:2k], R[11k +: 11]}, 13 bits.
- Extension: when sign=1, sign-extend each lane field from its MSB (guard bit included) to ACC_W; when sign=0, zero-extend.
- sign is taken per beat.
- mode is latched on the first beat of a block. mode on later beats of the same block is ignored.
- acc_len is latched on the first beat of a block. A value of 0 is treated as 1.
- States: ACCUM and DRAIN.
- ACCUM:
  - in_ready=1.
  - First beat of a block: acc[k] <= lane_k for every k; lanes k>=NL are loaded with 0; beat counter <= 1.
  - Later beats: acc[k] <= acc[k] + lane_k; counter increments.
  - When the accepted beat makes counter == latched acc_len, go to DRAIN. out_valid rises the next cycle (1-cycle latency from the last accepted input beat).
- DRAIN:
  - in_ready=0.
  - Outputs: out_data = acc[idx], out_lane = idx, out_last = (idx == NL-1).
  - Each out_valid && out_ready increments idx.
  - On acceptance of the beat with out_last=1: out_valid falls the next cycle, state returns to ACCUM, idx=0, counter=0.
  - While out_ready=0, all outputs hold stable.
  - No ACCUM/DRAIN overlap, so a new block's first beat can be accepted at the earliest the cycle after the last drain beat.
- Reset (asynchronous, any state, including mid-block or mid-drain):
  - State ACCUM, in_ready=1, out_valid=0, out_data=0, out_lane=0, out_last=0.
  - Counters, idx and all accumulators cleared.
  - The partial block is discarded.
- in_valid while in_ready=0 is ignored; the upstream must hold the beat.

Test Plan:
- Mode 00, sign=0, acc_len=1, result_0=45'h0_0000_1234, result_1=0 -> one output beat: out_data=0x1234, out_lane=0, out_last=1, asserted the cycle after input acceptance.
- Mode 11, sign=0, acc_len=1, R field k = k+1, carry=0 -> 8 beats: out_data 1..8 on lanes 0..7; out_last only on lane 7.
- Mode 11, sign=1, lane0 field=11'h7FF, carry[1:0]=2'b11 -> lane0 out_data = all ones (-1). Same word with sign=0 -> 0x1FFF.
- Mode 01, acc_len=3, lane0=5 and lane1=7 on each beat -> out_data 15 (lane 0), then 21 (lane 1). Mode driven to 11 on beats 2-3 is ignored.
- Backpressure: mode 10 drain with out_ready low for 4 cycles at lane 2 -> out_data and out_lane hold stable, in_ready stays 0, lane 3 follows once out_ready returns high.
- Reset asserted mid-drain at lane 1 of mode 11 -> out_valid=0 and in_ready=1 immediately. A subsequent block with acc_len=1, lane0=9 produces 9, with no residue from the aborted block.
